// File: rtl/cpu_pkg.sv
// Shared lab-CPU constants: phase codes, NZCV bit positions and default reset PC.
package cpu_pkg;

    // Phase codes seen by the decode/execute controller
    localparam logic [1:0] PH_FETCH = 2'b00;
    localparam logic [1:0] PH_READ  = 2'b01;
    localparam logic [1:0] PH_EXEC  = 2'b10;
    localparam logic [1:0] PH_WB    = 2'b11;

    // NZCV bit indices within the flag register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/phase_sequencer_if.sv
// Instruction-memory fetch port: address/request out, data/ready back.
interface phase_sequencer_if;

    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_ready;

    modport master (output imem_addr, output imem_rd, input imem_data, input imem_ready);
    modport slave  (input imem_addr, input imem_rd, output imem_data, output imem_ready);

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection at write-back: sequential pc+4 or pc+8+word offset.
module pc_next_calc (
    input  logic [31:0] pc_i,
    input  logic        bf_i,
    input  logic [23:0] offset_i,
    output logic [31:0] pc_next_o
);

    logic [31:0] disp;

    // Word offset is sign-extended and scaled to bytes; the +8 reflects
    // the pipeline-visible PC convention of the ISA.
    assign disp      = {{6{offset_i[23]}}, offset_i, 2'b00};
    assign pc_next_o = bf_i ? (pc_i + 32'd8 + disp) : (pc_i + 32'd4);

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase instruction sequencer: fetch handshake, PC, NZCV flags,
// halt/fetch-timeout parking and retired-instruction counter.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    phase_sequencer_if.master        imem,
    output logic [31:0]              instr,
    output logic [1:0]               state,
    output logic [31:0]              pc,
    output logic [31:0]              link_pc,
    input  logic                     bf,
    input  logic [23:0]              offset,
    input  logic [3:0]               flags_in,
    input  logic                     flags_we,
    output logic [3:0]               flags,
    input  logic                     halt,
    output logic                     halted,
    output logic                     fetch_err,
    output logic [31:0]              retired
);

    // Low two bits of the working states equal their phase codes; HALT is extra.
    localparam logic [2:0] S_FETCH = {1'b0, PH_FETCH};
    localparam logic [2:0] S_READ  = {1'b0, PH_READ};
    localparam logic [2:0] S_EXEC  = {1'b0, PH_EXEC};
    localparam logic [2:0] S_WB    = {1'b0, PH_WB};
    localparam logic [2:0] S_HALT  = 3'b100;

    localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [3:0]        flags_q, flags_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       retired_q, retired_d;
    logic              err_q, err_d;
    logic [31:0]       pc_next;

    pc_next_calc u_pc_next (
        .pc_i      (pc_q),
        .bf_i      (bf),
        .offset_i  (offset),
        .pc_next_o (pc_next)
    );

    // Phase progression and the per-phase register updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        flags_d   = flags_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        err_d     = err_q;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_data;
                    wait_d  = '0;
                    state_d = S_READ;
                end else if (int'(wait_q) >= FETCH_TIMEOUT - 1) begin
                    // Give up on this fetch; pc stays on the failing address.
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_READ: begin
                if (flags_we) flags_d = flags_in;
                state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                pc_d      = pc_next;
                retired_d = retired_q + 32'd1;
                state_d   = halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (!halt && !err_q) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State registers; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            flags_q   <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    // Outputs; HALT reports the FETCH phase code with the request dropped
    assign state          = (state_q == S_HALT) ? PH_FETCH : state_q[1:0];
    assign halted         = (state_q == S_HALT);
    assign imem.imem_rd   = !reset && (state_q == S_FETCH);
    assign imem.imem_addr = reset ? RESET_PC : pc_q;
    assign pc             = pc_q;
    assign link_pc        = pc_q + 32'd4;
    assign instr          = instr_q;
    assign flags          = flags_q;
    assign fetch_err      = err_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with a per-cycle reference model.
module tb_phase_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          TO  = 15;

    logic        clk;
    logic        rst, rdy, bf, fwe, hlt;
    logic [23:0] off;
    logic [3:0]  fin;
    logic [31:0] instr, pc, link_pc, retired;
    logic [1:0]  state;
    logic [3:0]  flags;
    logic        halted, fetch_err;

    int checks = 0;
    int errors = 0;

    phase_sequencer_if imem_bus ();

    // Instruction memory contents: address-dependent, never zero
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] p, input logic [23:0] o);
        int s;
        s = $signed(o);
        return p + 32'd8 + 32'(s * 4);
    endfunction

    assign imem_bus.imem_ready = rdy;
    assign imem_bus.imem_data  = rom(imem_bus.imem_addr);

    phase_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (rst),
        .imem      (imem_bus),
        .instr     (instr),
        .state     (state),
        .pc        (pc),
        .link_pc   (link_pc),
        .bf        (bf),
        .offset    (off),
        .flags_in  (fin),
        .flags_we  (fwe),
        .flags     (flags),
        .halt      (hlt),
        .halted    (halted),
        .fetch_err (fetch_err),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_ph 0..3 = phase of the current instruction, 4 = parked
    bit          m_valid = 0;
    int          m_ph, m_wait;
    logic [31:0] m_pc, m_instr, m_ret;
    logic [3:0]  m_flags;
    logic        m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1; m_ph <= 0; m_wait <= 0; m_pc <= RPC;
            m_instr <= 0; m_ret <= 0; m_flags <= 0; m_err <= 0;
        end else if (m_valid) begin
            case (m_ph)
                0: if (rdy) begin
                       m_instr <= rom(m_pc); m_wait <= 0; m_ph <= 1;
                   end else if (m_wait + 1 == TO) begin
                       m_err <= 1; m_wait <= 0; m_ph <= 4;
                   end else m_wait <= m_wait + 1;
                1: begin if (fwe) m_flags <= fin; m_ph <= 2; end
                2: m_ph <= 3;
                3: begin
                       m_pc  <= bf ? branch_target(m_pc, off) : m_pc + 32'd4;
                       m_ret <= m_ret + 1;
                       m_ph  <= hlt ? 4 : 0;
                   end
                default: if (!hlt && !m_err) m_ph <= 0;
            endcase
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",     state,     (m_ph == 4) ? 32'd0 : 32'(m_ph));
            chk("halted",    halted,    (m_ph == 4) ? 32'd1 : 32'd0);
            chk("imem_rd",   imem_bus.imem_rd, (!rst && m_ph == 0) ? 32'd1 : 32'd0);
            chk("imem_addr", imem_bus.imem_addr, rst ? RPC : m_pc);
            chk("pc",        pc,        m_pc);
            chk("link_pc",   link_pc,   m_pc + 32'd4);
            chk("instr",     instr,     m_instr);
            chk("flags",     flags,     m_flags);
            chk("retired",   retired,   m_ret);
            chk("fetch_err", fetch_err, m_err);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; rdy = 1; bf = 0; off = 0; fin = 0; fwe = 0; hlt = 0;
        cyc(3);
        chk("rst_state", state, 0);
        chk("rst_pc", pc, RPC);
        chk("rst_rd", imem_bus.imem_rd, 0);
        rst = 0;

        // Zero-wait run: three sequential instructions
        cyc(12);
        chk("zw_retired", retired, 3);
        chk("zw_pc", pc, 32'hC);
        chk("zw_instr", instr, rom(32'h8));

        // Three wait cycles before the handshake: 7-cycle instruction
        rdy = 0;
        cyc(3);
        chk("ws_state", state, 0);
        rdy = 1;
        cyc(1);
        chk("ws_read", state, 1);
        chk("ws_instr", instr, rom(32'hC));
        cyc(3);
        chk("ws_retired", retired, 4);
        chk("ws_pc", pc, 32'h10);
        chk("ws_err", fetch_err, 0);

        // Branches: 0x10 -> 0x100, self-loop, then forward to 0x148
        bf = 1; off = 24'h00003A;
        cyc(4);
        chk("br_to100", pc, 32'h100);
        off = 24'hFFFFFE;
        cyc(4);
        chk("br_self", pc, 32'h100);
        off = 24'h000010;
        cyc(4);
        chk("br_fwd", pc, 32'h148);
        chk("br_link", link_pc, 32'h14C);
        bf = 0;

        // Flags: written at end of READ, ignored in EXEC
        cyc(1);
        fwe = 1; fin = 4'b0100;
        cyc(1);
        chk("fl_read", flags, 4'b0100);
        fin = 4'b1000;
        cyc(1);
        chk("fl_exec", flags, 4'b0100);
        fwe = 0;
        cyc(1);

        // halt raised in EXEC: instruction still retires, then park
        cyc(2);
        hlt = 1;
        cyc(1);
        chk("hl_wb_ret", retired, 8);
        cyc(1);
        chk("hl_halted", halted, 1);
        chk("hl_ret", retired, 9);
        chk("hl_pc", pc, 32'h150);
        chk("hl_rd", imem_bus.imem_rd, 0);
        cyc(3);
        chk("hl_stay", halted, 1);
        hlt = 0;
        cyc(1);
        chk("hl_resume", imem_bus.imem_addr, 32'h150);
        chk("hl_rd1", imem_bus.imem_rd, 1);

        // halt and branch together at WB: branch applied, then park
        hlt = 1; bf = 1; off = 24'h000002;
        cyc(4);
        chk("hb_halted", halted, 1);
        chk("hb_pc", pc, 32'h160);
        hlt = 0; bf = 0;
        cyc(1);
        chk("hb_resume", imem_bus.imem_addr, 32'h160);

        // Fetch timeout: error after TO not-ready cycles, sticky until reset
        rdy = 0;
        cyc(TO - 1);
        chk("to_before", fetch_err, 0);
        cyc(1);
        chk("to_err", fetch_err, 1);
        chk("to_halted", halted, 1);
        chk("to_rd", imem_bus.imem_rd, 0);
        chk("to_pc", pc, 32'h160);
        rdy = 1;
        cyc(5);
        chk("to_sticky", fetch_err, 1);
        chk("to_parked", halted, 1);

        // Reset clears error; run to pc=0x20 with flags set, reset in EXEC
        rst = 1;
        cyc(1);
        rst = 0; fwe = 1; fin = 4'b1111;
        cyc(32);
        cyc(2);
        chk("rx_exec", state, 2'b10);
        chk("rx_pc", pc, 32'h20);
        chk("rx_flags", flags, 4'b1111);
        rst = 1;
        cyc(1);
        chk("rx_state", state, 0);
        chk("rx_pc0", pc, RPC);
        chk("rx_flags0", flags, 0);
        chk("rx_ret0", retired, 0);
        chk("rx_err0", fetch_err, 0);
        rst = 0; fwe = 0;
        cyc(4);
        chk("rx_first_pc", pc, 32'h4);
        chk("rx_first_ret", retired, 1);

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
